// File: rtl/arb_pkg.sv
// Shared types and the round-robin search helper for the req/gnt arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    // Widest requester vector the helper supports.
    localparam int unsigned MAX_REQ = 32;

    // Index of the first set bit of req at or after start, wrapping modulo num_req.
    // Returns num_req when no bit is set.
    function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        start,
                                            input int unsigned        num_req);
        int unsigned idx;
        logic        found;
        rr_next = num_req;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num_req) begin
                idx = start + i;
                if (idx >= num_req) idx = idx - num_req;
                if (!found && req[idx[4:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner search with an exclusion mask.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     start,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     winner_idx,
    output logic               found
);

    logic [MAX_REQ-1:0] cand;
    int unsigned        idx;

    // Search the masked request vector starting at the priority index.
    always_comb begin
        cand               = '0;
        cand[NUM_REQ-1:0]  = req & ~excl;
        idx                = rr_next(cand, 32'(start), NUM_REQ);
        found              = (idx < NUM_REQ);
        winner_idx         = found ? IDW'(idx) : '0;
        winner             = found ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/rr_req_gnt_arbiter_sva.sv
// Protocol checks bound into every rr_req_gnt_arbiter instance.
module rr_req_gnt_arbiter_sva #(
    parameter int unsigned NUM_REQ = 4
) (
    input logic               clk,
    input logic               res,
    input logic [NUM_REQ-1:0] req,
    input logic [NUM_REQ-1:0] gnt,
    input logic               busy
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (res) $onehot0(gnt));

    // A lone request seen while idle must be granted on the following cycle.
    a_uncontended: assert property (@(posedge clk) disable iff (res)
        (!busy && $onehot(req)) |=> (gnt == $past(req)));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_past_req
        a_gnt_had_req: assert property (@(posedge clk) disable iff (res)
            gnt[i] |-> $past(req[i]));
    end

endmodule

bind rr_req_gnt_arbiter rr_req_gnt_arbiter_sva #(
    .NUM_REQ(NUM_REQ)
) u_sva (
    .clk (clk),
    .res (res),
    .req (req),
    .gnt (gnt),
    .busy(busy)
);

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a per-owner hold limit.
module rr_req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               busy,
    output logic               preempt
);

    localparam int unsigned     HW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    // Counter parks here so a late-arriving competitor still triggers expiry.
    localparam logic [HW-1:0]   HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               preempt_q, preempt_d;

    logic [IDW-1:0]     start;
    logic [NUM_REQ-1:0] excl;
    logic [NUM_REQ-1:0] winner;
    logic [IDW-1:0]     winner_idx;
    logic               found;
    logic               owner_req;
    logic               others_req;
    logic               expire;
    logic               take;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_REQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    // While granted, search starts after the owner and never picks the owner again.
    always_comb begin
        start      = (state_q == GRANT) ? wrap_inc(gnt_id_q) : ptr_q;
        excl       = (state_q == GRANT) ? gnt_q : '0;
        owner_req  = |(req & gnt_q);
        others_req = |(req & ~gnt_q);
        expire     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && owner_req && others_req;
    end

    rr_priority_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req),
        .start     (start),
        .excl      (excl),
        .winner    (winner),
        .winner_idx(winner_idx),
        .found     (found)
    );

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            preempt_q <= preempt_d;
        end
    end

    // Next-state logic: leave GRANT only when the owner releases and nobody else waits.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = found ? GRANT : IDLE;
            GRANT:   state_d = (!owner_req && !found) ? IDLE : GRANT;
            default: state_d = IDLE;
        endcase
    end

    // Grant, pointer and hold counter updates.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        take      = 1'b0;
        case (state_q)
            IDLE: take = found;
            GRANT: begin
                if (!owner_req) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        gnt_d  = '0;
                        hold_d = '0;
                    end
                end else if (expire) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
        if (take) begin
            gnt_d    = winner;
            gnt_id_d = winner_idx;
            ptr_d    = wrap_inc(winner_idx);
            hold_d   = '0;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = |gnt_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Randomized and directed bench for rr_req_gnt_arbiter against a behavioural model.
module tb_rr_req_gnt_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         res;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         preempt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: current owner (-1 = none), priority start, cycles owned.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_owned = 0;
    bit m_pre   = 1'b0;

    always #5 clk = ~clk;

    rr_req_gnt_arbiter #(
        .NUM_REQ (N),
        .MAX_HOLD(MH)
    ) u_dut (
        .clk    (clk),
        .res    (res),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .preempt(preempt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (start + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_owned = 1;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        int           w;
        m_pre = 1'b0;
        if (res) begin
            m_owner = -1;
            m_ptr   = 0;
            m_owned = 0;
        end else if (m_owner < 0) begin
            w = first_from(req, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            others          = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner]) begin
                w = first_from(others, m_owner + 1);
                if (w >= 0) model_grant(w);
                else begin
                    m_owner = -1;
                    m_owned = 0;
                end
            end else if (MH != 0 && m_owned >= MH && others != '0) begin
                model_grant(first_from(others, m_owner + 1));
                m_pre = 1'b1;
            end else begin
                m_owned++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check_eq({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
        check_eq({tag, "_preempt"}, 32'(preempt), 32'(m_pre));
        if (m_owner >= 0) check_eq({tag, "_id"}, 32'(gnt_id), 32'(m_owner));
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rs, input string tag);
        @(negedge clk);
        req = r;
        res = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int           exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] r;
        int           pc;
        int           gc;

        req = '0;
        res = 1'b1;

        // Reset with everybody requesting.
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b1, "t1");
            check_eq("t1_gnt_zero", 32'(gnt), 0);
        end

        // Single request and release.
        cycle(4'b0100, 1'b0, "t2");
        check_eq("t2_gnt", 32'(gnt), 32'h4);
        check_eq("t2_id", 32'(gnt_id), 2);
        cycle(4'b0000, 1'b0, "t2");
        check_eq("t2_drop", 32'(gnt), 0);

        // Fairness: each owner releases right after its grant.
        cycle(4'b0000, 1'b1, "t3r");
        for (int k = 0; k < 5; k++) begin
            r = 4'b1111;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            cycle(r, 1'b0, "t3");
            check_eq($sformatf("t3_order%0d", k), 32'(gnt_id), 32'(exp_order[k]));
            check_eq($sformatf("t3_busy%0d", k), 32'(busy), 1);
        end
        cycle(4'b0000, 1'b0, "t3");

        // Hold limit: requester 3 joins while 0 owns.
        cycle(4'b0000, 1'b1, "t4r");
        for (int k = 0; k < 20; k++) begin
            r = (k >= 2) ? 4'b1001 : 4'b0001;
            cycle(r, 1'b0, "t4");
            if (k <= 7) check_eq($sformatf("t4_own%0d", k), 32'(gnt), 32'h1);
            if (k == 8) begin
                check_eq("t4_move", 32'(gnt), 32'h8);
                check_eq("t4_preempt", 32'(preempt), 1);
            end
            if (k == 9) check_eq("t4_pulse_end", 32'(preempt), 0);
        end
        cycle(4'b0000, 1'b0, "t4");

        // Lone owner past the limit keeps the grant.
        cycle(4'b0000, 1'b1, "t5r");
        pc = 0;
        gc = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(4'b0010, 1'b0, "t5");
            if (preempt) pc++;
            if (gnt == 4'b0010) gc++;
        end
        check_eq("t5_gnt_cycles", 32'(gc), 30);
        check_eq("t5_no_preempt", 32'(pc), 0);
        cycle(4'b0000, 1'b0, "t5");

        // Reset mid-grant clears the grant and the pointer.
        cycle(4'b0010, 1'b0, "t6");
        check_eq("t6_gnt", 32'(gnt), 32'h2);
        cycle(4'b0010, 1'b1, "t6");
        check_eq("t6_rst_drop", 32'(gnt), 0);
        cycle(4'b0000, 1'b0, "t6");
        cycle(4'b0011, 1'b0, "t6");
        check_eq("t6_first", 32'(gnt), 32'h1);
        cycle(4'b0000, 1'b0, "t6");
        // Owner 0 leaves ptr at 1; only a reset can restore 0 as top priority.
        cycle(4'b0001, 1'b0, "t6b");
        cycle(4'b0001, 1'b1, "t6b");
        cycle(4'b0000, 1'b0, "t6b");
        cycle(4'b0011, 1'b0, "t6b");
        check_eq("t6b_first", 32'(gnt), 32'h1);
        cycle(4'b0000, 1'b0, "t6b");

        // Random traffic with sticky requests and rare resets.
        r = '0;
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r, ($urandom_range(0, 79) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
